window_fetch_sequencer: RTL and testbench
=========================================

Name: window_fetch_sequencer

Overview:
- Upstream stage of address_translator in the memory manager.
- Walks the search-window and template-window coordinates of a range of sets for one frame buffer.
- Presents one (frame, set, tem_win, row, col) tuple per transfer on a valid/ready interface; the translator and SRAM read port consume the tuple.
- One sequence is started by a start pulse. The block reports busy, done and a range error.

Parameters:
- NUM_SETS, 150, number of sets per frame buffer; legal set indices are 0..NUM_SETS-1.
- SRCH_ROWS, 16, search-window rows walked per set.
- SRCH_COLS, 4, search-window columns walked per set.
- TEM_ROWS, 20, template-window rows walked per set.
- TEM_COLS, 20, template-window columns walked per set.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sequence.
- frame_in  input  1  frame buffer (0/1) for the sequence, sampled with start.
- set_first  input  8  first set index, sampled with start.
- set_last  input  8  last set index (inclusive), sampled with start.
- abort  input  1  terminates an active sequence.
- out_ready  input  1  downstream accepts the current tuple.
- out_valid  output  1  tuple on row/col/tem_win/set/frame is valid.
- row  output  7  window row.
- col  output  7  window column.
- tem_win  output  1  0 = search window, 1 = template window.
- set  output  8  current set index.
- frame  output  1  latched frame_in.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse when a sequence completes or is aborted.
- range_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset takes priority over every other input, including mid-sequence; the partial sequence is discarded and no done pulse is issued.
- States: IDLE, SRCH, TEM, FIN.
- IDLE:
  - start with set_first <= set_last < NUM_SETS: latch frame_in and set_first. Next cycle the state is SRCH with row=col=0, tem_win=0, out_valid=1 and busy=1.
  - start with an illegal range: range_err pulses the next cycle and the state stays IDLE.
- Start latency: start sampled in cycle N gives the first tuple valid in cycle N+1.
- start while busy is ignored and produces no error.
- Handshake:
  - A transfer occurs on a cycle with out_valid && out_ready.
  - While out_valid && !out_ready, all tuple outputs hold stable.
  - out_valid never drops without a transfer, except on abort or reset.
  - With out_ready held at 1, one tuple is transferred per cycle with no bubbles, including across the window and set boundaries.
- Advance on transfer:
  - col increments. At col = last column it wraps to 0 and row increments.
  - At the last row and last column of SRCH: enter TEM with row=col=0 and tem_win=1.
  - At the last tuple of TEM:
    - If set < latched set_last: increment set and enter SRCH with row=col=0.
    - Otherwise: enter FIN with out_valid=0.
- FIN lasts one cycle. done=1 and busy=0 take effect when FIN is entered, so done rises in the cycle after the final transfer. The next cycle returns to IDLE with done=0.
- Tuples per set: SRCH_ROWS*SRCH_COLS + TEM_ROWS*TEM_COLS = 464 at the defaults.
- Abort while busy: the next cycle has out_valid=0, then FIN (done pulse), then IDLE. A tuple presented in the abort cycle is still transferred if out_ready=1 in that cycle.
- Abort in IDLE has no effect. Abort and start in the same IDLE cycle: start wins.
- Counters:
  - row and col are 7 bits and are zero-extended compares against the parameter minus 1.
  - set is 8 bits.
  - Parameters must satisfy dims <= 128 and NUM_SETS <= 256; this is checked by an elaboration-time assertion.

Decomposition:
- Shared package memory_pkg:
  - NUM_SETS and the four window dimension constants.
  - FRAME_OFFSET and SET_STRIDE, which the translator also uses.
  - State enum seq_state_t {IDLE, SRCH, TEM, FIN}.
  - Typedef fetch_tuple_t packing frame, set, tem_win, row and col.
- Sub-module window_counter:
  - Parameterised row/col counter with inputs clear, advance, last_row and last_col.
  - Outputs row, col and a wrap flag.
  - Instanced once and reloaded with the dimensions of the active window on entering SRCH or TEM.

Test Plan:
- Full-speed single set: start with frame_in=1, set_first=set_last=5, out_ready=1.
  - 464 consecutive tuples, all with frame=1 and set=5.
  - Tuple 0 is (tem_win=0, row 0, col 0); tuple 63 is (0, 15, 3); tuple 64 is (1, 0, 0); tuple 463 is (1, 19, 19).
  - done pulses exactly 1 cycle after tuple 463.
- Backpressure: set 0, out_ready toggled 1,0,0,1 repeating.
  - Outputs hold stable through stalled cycles and no tuple is skipped or duplicated (scoreboard compare).
  - Total transfers = 464.
- Multi-set boundary: set_first=148, set_last=149.
  - 928 tuples; transfer 464 is (set 149, tem_win 0, 0, 0).
  - The set never reaches 150.
- Range errors:
  - set_first=10, set_last=9: range_err pulses and busy stays 0.
  - set_last=150: same response.
- Abort and ignored start: abort after 100 transfers.
  - out_valid falls the next cycle and done pulses once.
  - A start issued mid-sequence is ignored.
- Reset mid-sequence: assert reset at transfer 200.
  - Next cycle all outputs are 0 and no done pulse occurs.
  - A following start restarts cleanly at (0, 0, 0).

Source files
------------

// File: rtl/memory_pkg.sv
// Shared memory-manager constants and types.
// Used by the window fetch sequencer and the address translator.
package memory_pkg;

    localparam int NUM_SETS  = 150;
    localparam int SRCH_ROWS = 16;
    localparam int SRCH_COLS = 4;
    localparam int TEM_ROWS  = 20;
    localparam int TEM_COLS  = 20;

    localparam int SET_STRIDE   = SRCH_ROWS * SRCH_COLS + TEM_ROWS * TEM_COLS;
    localparam int FRAME_OFFSET = NUM_SETS * SET_STRIDE;

    typedef enum logic [1:0] {
        IDLE,
        SRCH,
        TEM,
        FIN
    } seq_state_t;

    typedef struct packed {
        logic       frame;
        logic [7:0] set;
        logic       tem_win;
        logic [6:0] row;
        logic [6:0] col;
    } fetch_tuple_t;

endpackage

// File: rtl/window_counter.sv
// Row/column walker for one window.
// Limits may change between windows; clear reloads to the origin.
module window_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] last_row,
    input  logic [W-1:0] last_col,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         wrap
);

    assign wrap = (row == last_row) && (col == last_col);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == last_col) begin
                col <= '0;
                row <= (row == last_row) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/window_fetch_sequencer.sv
// Walks search/template window coordinates over a range of sets
// and presents one tuple per valid/ready transfer.
module window_fetch_sequencer
    import memory_pkg::*;
#(
    parameter int P_NUM_SETS  = NUM_SETS,
    parameter int P_SRCH_ROWS = SRCH_ROWS,
    parameter int P_SRCH_COLS = SRCH_COLS,
    parameter int P_TEM_ROWS  = TEM_ROWS,
    parameter int P_TEM_COLS  = TEM_COLS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_in,
    input  logic [7:0] set_first,
    input  logic [7:0] set_last,
    input  logic       abort,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [6:0] row,
    output logic [6:0] col,
    output logic       tem_win,
    output logic [7:0] set,
    output logic       frame,
    output logic       busy,
    output logic       done,
    output logic       range_err
);

    if (P_SRCH_ROWS > 128 || P_SRCH_COLS > 128 || P_TEM_ROWS > 128 ||
        P_TEM_COLS > 128 || P_NUM_SETS > 256) begin : g_param_check
        $error("window_fetch_sequencer: parameter out of range");
    end

    localparam logic [8:0] NS = 9'(P_NUM_SETS);

    seq_state_t   state_q, state_d;
    logic         drain_q, drain_d;
    logic         frame_q;
    logic [7:0]   set_q, set_d, last_q;
    logic         range_err_q;
    logic [6:0]   last_row, last_col, cnt_row, cnt_col;
    logic         wrap, xfer, legal, start_ok, start_bad, clear;
    fetch_tuple_t tuple;

    assign legal     = (set_first <= set_last) && ({1'b0, set_last} < NS);
    assign start_ok  = (state_q == IDLE) && start && legal;
    assign start_bad = (state_q == IDLE) && start && !legal;

    assign busy      = (state_q == SRCH) || (state_q == TEM);
    assign out_valid = busy && !drain_q;
    assign xfer      = out_valid && out_ready;
    assign clear     = start_ok || (xfer && wrap);

    assign last_row = (state_q == TEM) ? 7'(P_TEM_ROWS - 1) : 7'(P_SRCH_ROWS - 1);
    assign last_col = (state_q == TEM) ? 7'(P_TEM_COLS - 1) : 7'(P_SRCH_COLS - 1);

    window_counter #(.W(7)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (xfer),
        .last_row(last_row),
        .last_col(last_col),
        .row     (cnt_row),
        .col     (cnt_col),
        .wrap    (wrap)
    );

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        set_d   = set_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SRCH;
                    set_d   = set_first;
                end
            end
            SRCH, TEM: begin
                if (drain_q) begin
                    state_d = FIN;
                end else begin
                    if (xfer && wrap) begin
                        if (state_q == SRCH) begin
                            state_d = TEM;
                        end else if (set_q < last_q) begin
                            set_d   = set_q + 1'b1;
                            state_d = SRCH;
                        end else begin
                            state_d = FIN;
                        end
                    end
                    // A completion in the abort cycle already ends the run.
                    if (abort && state_d != FIN) drain_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            drain_q     <= 1'b0;
            set_q       <= '0;
            last_q      <= '0;
            frame_q     <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            set_q       <= set_d;
            range_err_q <= start_bad;
            if (start_ok) begin
                frame_q <= frame_in;
                last_q  <= set_last;
            end
        end
    end

    assign tuple = '{frame: frame_q, set: set_q, tem_win: (state_q == TEM),
                     row: cnt_row, col: cnt_col};

    assign frame     = tuple.frame;
    assign set       = tuple.set;
    assign tem_win   = tuple.tem_win;
    assign row       = tuple.row;
    assign col       = tuple.col;
    assign done      = (state_q == FIN);
    assign range_err = range_err_q;

endmodule

// File: tb/tb_window_fetch_sequencer.sv
// Directed self-checking bench for window_fetch_sequencer.
module tb_window_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, frame_in, abort, out_ready;
    logic [7:0] set_first, set_last;
    logic       out_valid, tem_win, frame, busy, done, range_err;
    logic [6:0] row, col;
    logic [7:0] set;
    logic [27:0] obs;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    window_fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .frame_in(frame_in),
        .set_first(set_first), .set_last(set_last), .abort(abort),
        .out_ready(out_ready), .out_valid(out_valid), .row(row), .col(col),
        .tem_win(tem_win), .set(set), .frame(frame), .busy(busy),
        .done(done), .range_err(range_err)
    );

    assign obs = {out_valid, busy, done, range_err, frame, set, tem_win, row, col};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected output vector while tuple k of a run is presented.
    function automatic logic [27:0] exp_tuple(input logic f, input int first, input int k);
        int s, r, rw, cl;
        logic t;
        s = first + k / 464;
        r = k % 464;
        if (r < 64) begin
            t = 1'b0; rw = r / 4; cl = r % 4;
        end else begin
            t = 1'b1; rw = (r - 64) / 20; cl = (r - 64) % 20;
        end
        return {1'b1, 1'b1, 1'b0, 1'b0, f, 8'(s), t, 7'(rw), 7'(cl)};
    endfunction

    task automatic kick(input logic f, input int first, input int last);
        frame_in  = f;
        set_first = 8'(first);
        set_last  = 8'(last);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic run_seq(input logic f, input int first, input int last);
        int n;
        n = (last - first + 1) * 464;
        out_ready = 1'b1;
        kick(f, first, last);
        for (int k = 0; k < n; k++) begin
            check("seq_tuple", 32'(obs), 32'(exp_tuple(f, first, k)));
            if (first == 5 && k == 0)
                check("t0", {tem_win, row, col}, {1'b0, 7'd0, 7'd0});
            if (first == 5 && k == 63)
                check("t63", {tem_win, row, col}, {1'b0, 7'd15, 7'd3});
            if (first == 5 && k == 64)
                check("t64", {tem_win, row, col}, {1'b1, 7'd0, 7'd0});
            if (first == 5 && k == 463)
                check("t463", {tem_win, row, col}, {1'b1, 7'd19, 7'd19});
            if (first == 148 && k == 464)
                check("t464_set", {set, tem_win, row, col}, {8'd149, 1'b0, 7'd0, 7'd0});
            step();
        end
        check("done_pulse", {out_valid, busy, done}, 3'b001);
        step();
        check("done_clear", {out_valid, busy, done}, 3'b000);
    endtask

    initial begin
        int xfers;
        int cyc;
        reset = 1'b1; start = 1'b0; frame_in = 1'b0; abort = 1'b0;
        out_ready = 1'b0; set_first = '0; set_last = '0;
        step(); step(); step();
        check("reset_state", 32'(obs), 32'd0);
        reset = 1'b0;
        step();
        check("idle_state", 32'(obs), 32'd0);

        run_seq(1'b1, 5, 5);

        kick(1'b0, 0, 0);
        xfers = 0;
        cyc = 0;
        while (!done && cyc < 4000) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            check("bp_tuple", 32'(obs), 32'(exp_tuple(1'b0, 0, xfers)));
            if (out_valid && out_ready) xfers++;
            step();
            cyc++;
        end
        check("bp_count", xfers, 464);
        check("bp_done", {out_valid, done}, 2'b01);
        out_ready = 1'b1;
        step();

        run_seq(1'b0, 148, 149);

        kick(1'b0, 10, 9);
        check("rerr_order", {range_err, busy, out_valid}, 3'b100);
        step();
        check("rerr_order_clr", {range_err, busy, out_valid}, 3'b000);
        kick(1'b1, 0, 150);
        check("rerr_limit", {range_err, busy, out_valid}, 3'b100);
        step();
        check("rerr_limit_clr", {range_err, busy, out_valid}, 3'b000);

        out_ready = 1'b1;
        kick(1'b1, 3, 3);
        for (int k = 0; k <= 100; k++) begin
            check("ab_tuple", 32'(obs), 32'(exp_tuple(1'b1, 3, k)));
            if (k == 50) begin
                start = 1'b1; frame_in = 1'b0; set_first = 8'd0; set_last = 8'd0;
            end
            if (k == 51) start = 1'b0;
            if (k == 100) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        check("ab_drain", {out_valid, done, range_err}, 3'b000);
        step();
        check("ab_done", {out_valid, busy, done}, 3'b001);
        step();
        check("ab_idle", {out_valid, busy, done}, 3'b000);

        kick(1'b1, 7, 7);
        for (int k = 0; k < 200; k++) begin
            check("rs_tuple", 32'(obs), 32'(exp_tuple(1'b1, 7, k)));
            step();
        end
        reset = 1'b1;
        step();
        check("rs_zero", 32'(obs), 32'd0);
        reset = 1'b0;
        step();
        check("rs_nodone", 32'(obs), 32'd0);
        step();
        check("rs_nodone2", {busy, done}, 2'b00);

        run_seq(1'b0, 2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
